// File: rtl/stack_pkg.sv
// Shared types and defaults for the CPU data stack: word/depth defaults,
// error-mode encoding and the push/pop operation decode.
package stack_pkg;

  localparam int STACK_WORD_W    = 16;
  localparam int STACK_DEPTH_DEF = 32;

  typedef enum logic {
    IDLE,
    ERR
  } stack_mode_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPL
  } stack_op_t;

  function automatic stack_op_t decode_op(input logic push, input logic pop);
    if (push && pop) return OP_REPL;
    else if (push)   return OP_PUSH;
    else if (pop)    return OP_POP;
    else             return OP_NONE;
  endfunction

endpackage

// File: rtl/data_stack_if.sv
// Control-FSM to data-stack interface. The next-of-stack signals exist only
// when DSTACK_NOS_EN is defined.
interface data_stack_if #(
  parameter int WIDTH = stack_pkg::STACK_WORD_W,
  parameter int PTR_W = $clog2(stack_pkg::STACK_DEPTH_DEF)
);
  logic             rst_stack;
  logic             push_stack;
  logic             pop_stack;
  logic [WIDTH-1:0] stack_data_in;
  logic [WIDTH-1:0] stack_data_out;
  logic [WIDTH-1:0] tos_data;
  logic [PTR_W:0]   tos_pointer;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;
`ifdef DSTACK_NOS_EN
  logic [WIDTH-1:0] nos_data;
  logic             nos_valid;
`endif

  modport master (
    output rst_stack, push_stack, pop_stack, stack_data_in,
    input  stack_data_out, tos_data, tos_pointer, empty, full, overflow, underflow
`ifdef DSTACK_NOS_EN
    , input nos_data, nos_valid
`endif
  );

  modport slave (
    input  rst_stack, push_stack, pop_stack, stack_data_in,
    output stack_data_out, tos_data, tos_pointer, empty, full, overflow, underflow
`ifdef DSTACK_NOS_EN
    , output nos_data, nos_valid
`endif
  );

endinterface

// File: rtl/stack_ram.sv
// Stack storage: DEPTH x WIDTH register array, one synchronous write port and
// two asynchronous read ports. Contents are not reset.
module stack_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr_a,
  input  logic [PTR_W-1:0] raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/data_stack.sv
// LIFO data stack for the 16-bit stack CPU with sticky overflow/underflow.
// Optional DSTACK_NOS_EN adds a registered next-of-stack output.
//
// state | meaning
// IDLE  | no error seen since the last clear
// ERR   | an overflow or underflow occurred; operations still execute
module data_stack
  import stack_pkg::*;
#(
  parameter int WIDTH = STACK_WORD_W,
  parameter int DEPTH = STACK_DEPTH_DEF,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input logic        clk,
  input logic        rst,
  data_stack_if.slave bus
);

  localparam logic [PTR_W:0] CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] CNT_TWO   = (PTR_W+1)'(2);
  localparam logic [PTR_W:0] CNT_THREE = (PTR_W+1)'(3);
  localparam logic [PTR_W:0] CNT_FULL  = (PTR_W+1)'(DEPTH);

  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] tos_q, tos_d, dout_q, dout_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             err_evt, clear, is_empty, is_full;
  stack_mode_t      mode_q, mode_d;
  stack_op_t        op;

  logic             we;
  logic [PTR_W-1:0] waddr, cnt_lo, raddr_a, raddr_b;
  logic [WIDTH-1:0] rdata_a, rdata_b, top_word;

  assign clear    = rst | bus.rst_stack;
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_FULL);
  assign cnt_lo   = count_q[PTR_W-1:0];
  assign op       = decode_op(bus.push_stack, bus.pop_stack);

  // Port A always looks at what becomes the top after a pop (count-2).
  assign raddr_a = cnt_lo - PTR_W'(2);
`ifdef DSTACK_NOS_EN
  logic [WIDTH-1:0] nos_q, nos_d;
  // Port B fetches the post-pop next-of-stack; the old top is already in tos_q.
  assign raddr_b  = cnt_lo - PTR_W'(3);
  assign top_word = tos_q;
`else
  assign raddr_b  = cnt_lo - PTR_W'(1);
  assign top_word = rdata_b;
`endif

  stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk     (clk),
    .we      (we),
    .waddr   (waddr),
    .wdata   (bus.stack_data_in),
    .raddr_a (raddr_a),
    .raddr_b (raddr_b),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );

  always_comb begin
    count_d = count_q;
    tos_d   = tos_q;
    dout_d  = dout_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    we      = 1'b0;
    waddr   = cnt_lo;
    err_evt = 1'b0;
`ifdef DSTACK_NOS_EN
    nos_d   = nos_q;
`endif
    case (op)
      OP_PUSH: begin
        if (is_full) begin
          ovf_d   = 1'b1;
          err_evt = 1'b1;
        end else begin
          we      = 1'b1;
          count_d = count_q + CNT_ONE;
          tos_d   = bus.stack_data_in;
`ifdef DSTACK_NOS_EN
          nos_d   = tos_q;
`endif
        end
      end
      OP_POP: begin
        if (is_empty) begin
          unf_d   = 1'b1;
          err_evt = 1'b1;
        end else begin
          dout_d  = top_word;
          count_d = count_q - CNT_ONE;
          tos_d   = (count_q == CNT_ONE) ? '0 : rdata_a;
`ifdef DSTACK_NOS_EN
          nos_d   = (count_q >= CNT_THREE) ? rdata_b : '0;
`endif
        end
      end
      OP_REPL: begin
        we    = 1'b1;
        tos_d = bus.stack_data_in;
        if (is_empty) begin
          // Nothing to pop: the push still lands in entry 0.
          count_d = CNT_ONE;
          unf_d   = 1'b1;
          err_evt = 1'b1;
        end else begin
          waddr  = cnt_lo - PTR_W'(1);
          dout_d = top_word;
        end
      end
      default: ;
    endcase
    if (clear) begin
      count_d = '0;
      tos_d   = '0;
      dout_d  = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      we      = 1'b0;
`ifdef DSTACK_NOS_EN
      nos_d   = '0;
`endif
    end
  end

  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      IDLE:    if (err_evt) mode_d = ERR;
      ERR:     mode_d = ERR;
      default: mode_d = IDLE;
    endcase
    if (clear) mode_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      tos_q   <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      mode_q  <= IDLE;
`ifdef DSTACK_NOS_EN
      nos_q   <= '0;
`endif
    end else begin
      count_q <= count_d;
      tos_q   <= tos_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      mode_q  <= mode_d;
`ifdef DSTACK_NOS_EN
      nos_q   <= nos_d;
`endif
    end
  end

  assign bus.stack_data_out = dout_q;
  assign bus.tos_data       = tos_q;
  assign bus.tos_pointer    = count_q;
  assign bus.empty          = is_empty;
  assign bus.full           = is_full;
  assign bus.overflow       = ovf_q;
  assign bus.underflow      = unf_q;
`ifdef DSTACK_NOS_EN
  assign bus.nos_data       = nos_q;
  assign bus.nos_valid      = (count_q >= CNT_TWO);
`endif

endmodule

// File: tb/tb_data_stack.sv
// Directed self-checking bench for data_stack (default depth 32, width 16).
// Exercises the next-of-stack outputs when DSTACK_NOS_EN is defined.
module tb_data_stack;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  data_stack_if bus ();

  data_stack u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic push, input logic pop, input logic [15:0] d);
    bus.push_stack    = push;
    bus.pop_stack     = pop;
    bus.stack_data_in = d;
    tick();
    bus.push_stack = 1'b0;
    bus.pop_stack  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.rst_stack = 1'b0;
    bus.push_stack = 1'b0;
    bus.pop_stack = 1'b0;
    bus.stack_data_in = 16'h0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (bus.tos_pointer !== 6'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.tos_pointer); end
    checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin failures++; $display("FAIL reset_empty_full got=%b%b exp=10", bus.empty, bus.full); end
    checks++; if (bus.tos_data !== 16'h0 || bus.stack_data_out !== 16'h0) begin failures++; $display("FAIL reset_data got tos=%h out=%h exp=0", bus.tos_data, bus.stack_data_out); end
    checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", bus.overflow, bus.underflow); end
  endtask

  task automatic test_push_pop();
    logic [15:0] exp_out;
    op(1, 0, 16'h0001);
    op(1, 0, 16'h0002);
    op(1, 0, 16'h0003);
    checks++; if (bus.tos_pointer !== 6'd3) begin failures++; $display("FAIL push3_count got=%0d exp=3", bus.tos_pointer); end
    checks++; if (bus.tos_data !== 16'h0003) begin failures++; $display("FAIL push3_tos got=%h exp=0003", bus.tos_data); end
    for (int i = 3; i >= 1; i--) begin
      op(0, 1, 16'h0);
      exp_out = 16'(i);
      checks++; if (bus.stack_data_out !== exp_out) begin failures++; $display("FAIL pop_out got=%h exp=%h", bus.stack_data_out, exp_out); end
      checks++; if (bus.tos_data !== exp_out - 16'd1) begin failures++; $display("FAIL pop_tos got=%h exp=%h", bus.tos_data, exp_out - 16'd1); end
    end
    checks++; if (bus.empty !== 1'b1 || bus.tos_pointer !== 6'd0) begin failures++; $display("FAIL pop_empty got empty=%b cnt=%0d exp=1/0", bus.empty, bus.tos_pointer); end
    checks++; if (bus.underflow !== 1'b0) begin failures++; $display("FAIL pop_no_underflow got=%b exp=0", bus.underflow); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 32; i++) op(1, 0, 16'h0100 + 16'(i));
    checks++; if (bus.full !== 1'b1 || bus.tos_pointer !== 6'd32) begin failures++; $display("FAIL fill_full got full=%b cnt=%0d exp=1/32", bus.full, bus.tos_pointer); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL fill_no_ovf got=%b exp=0", bus.overflow); end
    op(1, 0, 16'hBEEF);
    checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", bus.overflow); end
    checks++; if (bus.tos_pointer !== 6'd32 || bus.tos_data !== 16'h011F) begin failures++; $display("FAIL ovf_hold got cnt=%0d tos=%h exp=32/011f", bus.tos_pointer, bus.tos_data); end
    op(0, 1, 16'h0);
    checks++; if (bus.stack_data_out !== 16'h011F || bus.tos_data !== 16'h011E) begin failures++; $display("FAIL pop_from_full got out=%h tos=%h exp=011f/011e", bus.stack_data_out, bus.tos_data); end
    op(0, 1, 16'h0);
    checks++; if (bus.stack_data_out !== 16'h011E || bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got out=%h ovf=%b exp=011e/1", bus.stack_data_out, bus.overflow); end
  endtask

  task automatic test_underflow();
    do_reset();
    op(1, 0, 16'h1234);
    op(0, 1, 16'h0);
    checks++; if (bus.stack_data_out !== 16'h1234 || bus.empty !== 1'b1) begin failures++; $display("FAIL unf_setup got out=%h empty=%b exp=1234/1", bus.stack_data_out, bus.empty); end
    op(0, 1, 16'h0);
    checks++; if (bus.underflow !== 1'b1) begin failures++; $display("FAIL unf_flag got=%b exp=1", bus.underflow); end
    checks++; if (bus.stack_data_out !== 16'h1234 || bus.tos_pointer !== 6'd0) begin failures++; $display("FAIL unf_hold got out=%h cnt=%0d exp=1234/0", bus.stack_data_out, bus.tos_pointer); end
    op(1, 0, 16'h0042);
    checks++; if (bus.underflow !== 1'b1 || bus.tos_data !== 16'h0042) begin failures++; $display("FAIL unf_sticky got unf=%b tos=%h exp=1/0042", bus.underflow, bus.tos_data); end
  endtask

  task automatic test_replace();
    do_reset();
    op(1, 0, 16'h0999);
    op(1, 0, 16'h0AAA);
    op(1, 1, 16'h0BBB);
    checks++; if (bus.stack_data_out !== 16'h0AAA || bus.tos_data !== 16'h0BBB) begin failures++; $display("FAIL repl_data got out=%h tos=%h exp=0aaa/0bbb", bus.stack_data_out, bus.tos_data); end
    checks++; if (bus.tos_pointer !== 6'd2 || bus.underflow !== 1'b0 || bus.overflow !== 1'b0) begin failures++; $display("FAIL repl_count got cnt=%0d flags=%b%b exp=2/00", bus.tos_pointer, bus.overflow, bus.underflow); end
    op(0, 1, 16'h0);
    checks++; if (bus.stack_data_out !== 16'h0BBB || bus.tos_data !== 16'h0999) begin failures++; $display("FAIL repl_pop got out=%h tos=%h exp=0bbb/0999", bus.stack_data_out, bus.tos_data); end
    do_reset();
    op(1, 1, 16'h0CCC);
    checks++; if (bus.tos_pointer !== 6'd1 || bus.underflow !== 1'b1) begin failures++; $display("FAIL repl_empty got cnt=%0d unf=%b exp=1/1", bus.tos_pointer, bus.underflow); end
    checks++; if (bus.stack_data_out !== 16'h0 || bus.tos_data !== 16'h0CCC) begin failures++; $display("FAIL repl_empty_data got out=%h tos=%h exp=0000/0ccc", bus.stack_data_out, bus.tos_data); end
    op(0, 1, 16'h0);
    checks++; if (bus.stack_data_out !== 16'h0CCC || bus.empty !== 1'b1) begin failures++; $display("FAIL repl_empty_pop got out=%h empty=%b exp=0ccc/1", bus.stack_data_out, bus.empty); end
  endtask

  task automatic test_clear();
    do_reset();
    for (int i = 0; i < 33; i++) op(1, 0, 16'h0200 + 16'(i));
    for (int i = 0; i < 27; i++) op(0, 1, 16'h0);
    checks++; if (bus.tos_pointer !== 6'd5 || bus.overflow !== 1'b1) begin failures++; $display("FAIL clr_setup got cnt=%0d ovf=%b exp=5/1", bus.tos_pointer, bus.overflow); end
    bus.rst_stack = 1'b1;
    op(1, 0, 16'hDEAD);
    bus.rst_stack = 1'b0;
    checks++; if (bus.tos_pointer !== 6'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin failures++; $display("FAIL clr_count got cnt=%0d empty=%b full=%b exp=0/1/0", bus.tos_pointer, bus.empty, bus.full); end
    checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0 || bus.tos_data !== 16'h0 || bus.stack_data_out !== 16'h0) begin failures++; $display("FAIL clr_state got flags=%b%b tos=%h out=%h exp=00/0/0", bus.overflow, bus.underflow, bus.tos_data, bus.stack_data_out); end
    op(0, 1, 16'h0);
    for (int i = 0; i < 6; i++) op(1, 0, 16'h0300 + 16'(i));
    op(0, 1, 16'h0);
    checks++; if (bus.tos_pointer !== 6'd5 || bus.underflow !== 1'b1 || bus.stack_data_out !== 16'h0305) begin failures++; $display("FAIL rst_setup got cnt=%0d unf=%b out=%h exp=5/1/0305", bus.tos_pointer, bus.underflow, bus.stack_data_out); end
    rst = 1'b1;
    op(0, 1, 16'h0);
    rst = 1'b0;
    checks++; if (bus.tos_pointer !== 6'd0 || bus.underflow !== 1'b0 || bus.stack_data_out !== 16'h0 || bus.tos_data !== 16'h0) begin failures++; $display("FAIL rst_pop got cnt=%0d unf=%b out=%h tos=%h exp=0/0/0/0", bus.tos_pointer, bus.underflow, bus.stack_data_out, bus.tos_data); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    op(1, 0, 16'h0050);
    op(0, 1, 16'h0);
    checks++; if (bus.stack_data_out !== 16'h0050) begin failures++; $display("FAIL b2b_first got=%h exp=0050", bus.stack_data_out); end
    op(1, 0, 16'h0060);
    checks++; if (bus.stack_data_out !== 16'h0050 || bus.tos_data !== 16'h0060) begin failures++; $display("FAIL b2b_hold got out=%h tos=%h exp=0050/0060", bus.stack_data_out, bus.tos_data); end
    op(1, 0, 16'h0070);
    op(0, 1, 16'h0);
    checks++; if (bus.stack_data_out !== 16'h0070 || bus.tos_data !== 16'h0060 || bus.tos_pointer !== 6'd1) begin failures++; $display("FAIL b2b_second got out=%h tos=%h cnt=%0d exp=0070/0060/1", bus.stack_data_out, bus.tos_data, bus.tos_pointer); end
  endtask

`ifdef DSTACK_NOS_EN
  task automatic test_nos();
    do_reset();
    checks++; if (bus.nos_valid !== 1'b0 || bus.nos_data !== 16'h0) begin failures++; $display("FAIL nos_reset got v=%b d=%h exp=0/0000", bus.nos_valid, bus.nos_data); end
    op(1, 0, 16'h0011);
    op(1, 0, 16'h0022);
    checks++; if (bus.nos_valid !== 1'b1 || bus.nos_data !== 16'h0011) begin failures++; $display("FAIL nos_two got v=%b d=%h exp=1/0011", bus.nos_valid, bus.nos_data); end
    op(0, 1, 16'h0);
    checks++; if (bus.nos_valid !== 1'b0 || bus.nos_data !== 16'h0) begin failures++; $display("FAIL nos_pop got v=%b d=%h exp=0/0000", bus.nos_valid, bus.nos_data); end
    op(1, 0, 16'h0033);
    op(1, 0, 16'h0044);
    checks++; if (bus.nos_data !== 16'h0033 || bus.tos_data !== 16'h0044) begin failures++; $display("FAIL nos_three got nos=%h tos=%h exp=0033/0044", bus.nos_data, bus.tos_data); end
    op(0, 1, 16'h0);
    checks++; if (bus.nos_valid !== 1'b1 || bus.nos_data !== 16'h0011 || bus.tos_data !== 16'h0033) begin failures++; $display("FAIL nos_pop3 got v=%b nos=%h tos=%h exp=1/0011/0033", bus.nos_valid, bus.nos_data, bus.tos_data); end
  endtask
`endif

  initial begin
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_replace();
    test_clear();
    test_back_to_back();
`ifdef DSTACK_NOS_EN
    test_nos();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
